// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM states, address width and the bus-event
// classification produced from synchronized SCL/SDA edges.
package i2c_pkg;

  localparam int I2C_ADDR_WIDTH = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_BYTE,
    ST_RX_ACK,
    ST_TX_BYTE,
    ST_TX_ACK,
    ST_WAIT_STOP
  } i2c_slave_state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_START,
    CMD_STOP,
    CMD_RISE,
    CMD_FALL
  } i2c_cmd_t;

endpackage

// File: rtl/i2c_sync.sv
// Multi-flop synchronizer for one bus line with rise/fall strobes derived
// from the synchronized previous and current levels. Idles high.
module i2c_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_q [SYNC_STAGES];
  logic prev_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave without clock stretching: address match, byte receive with
// rx_ready backpressure (NACK on refusal) and byte transmit with underrun fill.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_BITS   = 7
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 en,
  input  logic [ADDR_BITS-1:0] own_addr,
  input  logic                 scl_i,
  input  logic                 sda_i,
  output logic                 sda_oe,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic [7:0]           tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [5:0]           status
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
    .clk(clk), .arst_n(arst_n), .din(scl_i), .level(scl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
    .clk(clk), .arst_n(arst_n), .din(sda_i), .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_slave_state_t          state_q, state_d;
  logic [7:0]                shift_q, shift_d;
  logic [2:0]                cnt_q, cnt_d;
  logic                      sda_oe_d, rx_valid_d, tx_ready_d;
  logic [7:0]                rx_data_d;
  logic                      busy_q, busy_d, addressed_q, addressed_d, rw_q, rw_d;
  logic                      ovf_q, ovf_d, unr_q, unr_d, nack_q, nack_d;
  logic                      load_tx;
  i2c_cmd_t                  cmd;
  logic [7:0]                rx_byte, tx_byte;
  logic [I2C_ADDR_WIDTH-1:0] own_match;

  assign rx_byte   = {shift_q[6:0], sda};
  assign tx_byte   = tx_valid ? tx_data : 8'hFF;
  assign own_match = I2C_ADDR_WIDTH'(own_addr);
  assign status    = {ovf_q, unr_q, nack_q, rw_q, addressed_q, busy_q};

  // Bus conditions take priority over bit processing in the same cycle.
  always_comb begin
    cmd = CMD_NONE;
    if (scl && sda_fall)      cmd = CMD_START;
    else if (scl && sda_rise) cmd = CMD_STOP;
    else if (scl_rise)        cmd = CMD_RISE;
    else if (scl_fall)        cmd = CMD_FALL;
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    sda_oe_d    = sda_oe;
    rx_data_d   = rx_data;
    rx_valid_d  = 1'b0;
    tx_ready_d  = 1'b0;
    busy_d      = busy_q;
    addressed_d = addressed_q;
    rw_d        = rw_q;
    ovf_d       = 1'b0;
    unr_d       = 1'b0;
    nack_d      = 1'b0;
    load_tx     = 1'b0;
    if (!en) begin
      state_d     = ST_IDLE;
      shift_d     = 8'h00;
      cnt_d       = 3'd0;
      sda_oe_d    = 1'b0;
      rx_data_d   = 8'h00;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
      rw_d        = 1'b0;
    end else begin
      unique case (cmd)
        CMD_START, CMD_STOP: begin
          state_d     = (cmd == CMD_START) ? ST_ADDR : ST_IDLE;
          busy_d      = (cmd == CMD_START);
          addressed_d = 1'b0;
          shift_d     = 8'h00;
          cnt_d       = 3'd0;
          sda_oe_d    = 1'b0;
        end
        CMD_RISE: begin
          case (state_q)
            ST_ADDR, ST_RX_BYTE: begin
              shift_d = rx_byte;
              cnt_d   = cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                if (state_q == ST_ADDR) begin
                  rw_d        = rx_byte[0];
                  addressed_d = (rx_byte[7:1] == own_match);
                  state_d     = addressed_d ? ST_ADDR_ACK : ST_WAIT_STOP;
                end else if (rx_ready) begin
                  rx_data_d  = rx_byte;
                  rx_valid_d = 1'b1;
                  state_d    = ST_RX_ACK;
                end else begin
                  ovf_d   = 1'b1;
                  state_d = ST_WAIT_STOP;
                end
              end
            end
            ST_TX_BYTE: cnt_d = cnt_q + 3'd1;
            ST_TX_ACK: begin
              if (sda) begin
                nack_d  = 1'b1;
                state_d = ST_WAIT_STOP;
              end
            end
            default: ;
          endcase
        end
        CMD_FALL: begin
          case (state_q)
            // First fall asserts the ACK, the second one releases it.
            ST_ADDR_ACK, ST_RX_ACK: begin
              if (!sda_oe) begin
                sda_oe_d = 1'b1;
              end else begin
                sda_oe_d = 1'b0;
                cnt_d    = 3'd0;
                if (state_q == ST_ADDR_ACK && rw_q) load_tx = 1'b1;
                else                                state_d = ST_RX_BYTE;
              end
            end
            ST_TX_BYTE: begin
              if (cnt_q == 3'd0) begin
                sda_oe_d = 1'b0;
                state_d  = ST_TX_ACK;
              end else begin
                shift_d  = {shift_q[6:0], 1'b0};
                sda_oe_d = ~shift_q[6];
              end
            end
            // A master NACK already left TX_ACK on the rising edge.
            ST_TX_ACK: load_tx = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
      if (load_tx) begin
        state_d    = ST_TX_BYTE;
        shift_d    = tx_byte;
        sda_oe_d   = ~tx_byte[7];
        cnt_d      = 3'd0;
        tx_ready_d = tx_valid;
        unr_d      = ~tx_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= 8'h00;
      cnt_q       <= 3'd0;
      sda_oe      <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b0;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
      rw_q        <= 1'b0;
      ovf_q       <= 1'b0;
      unr_q       <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      sda_oe      <= sda_oe_d;
      rx_data     <= rx_data_d;
      rx_valid    <= rx_valid_d;
      tx_ready    <= tx_ready_d;
      busy_q      <= busy_d;
      addressed_q <= addressed_d;
      rw_q        <= rw_d;
      ovf_q       <= ovf_d;
      unr_q       <= unr_d;
      nack_q      <= nack_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged I2C master on a wired-AND SDA line,
// directed scenarios followed by randomized transactions against a byte-level model.
module tb_i2c_slave;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       arst_n, en;
  logic [6:0] own_addr;
  logic       scl_i, sda_m, sda_i;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [5:0] status;

  always #5 clk = ~clk;
  assign sda_i = sda_m & ~sda_oe;

  i2c_slave #(.SYNC_STAGES(2), .ADDR_BITS(7)) dut (
    .clk(clk), .arst_n(arst_n), .en(en), .own_addr(own_addr),
    .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .status(status)
  );

  int n_cmp = 0;
  int n_err = 0;
  int rxv_cnt = 0, txr_cnt = 0, ovf_cnt = 0, unr_cnt = 0, nack_cnt = 0, oe_cnt = 0;
  logic [7:0] last_rx = 8'h00;
  int s_rxv, s_txr, s_ovf, s_unr, s_nack, s_oe;

  // Pulse and drive-activity counters observed away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) begin rxv_cnt++; last_rx = rx_data; end
    if (tx_ready)  txr_cnt++;
    if (status[5]) ovf_cnt++;
    if (status[4]) unr_cnt++;
    if (status[3]) nack_cnt++;
    if (sda_oe)    oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_rxv = rxv_cnt; s_txr = txr_cnt; s_ovf = ovf_cnt;
    s_unr = unr_cnt; s_nack = nack_cnt; s_oe = oe_cnt;
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_bit(input logic d, output logic s);
    sda_m = d; wait_q();
    scl_i = 1'b1; wait_q();
    s = sda_i; wait_q();
    scl_i = 1'b0; wait_q();
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl_i = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_i = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl_i = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_bits(output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      b[i] = s;
    end
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] b;
    arst_n = 1'b0; en = 1'b1; own_addr = 7'h42;
    scl_i = 1'b1; sda_m = 1'b1;
    rx_ready = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_oe", sda_oe, 1'b0);
    check("rst_status", status, 6'd0);
    check("rst_rx", {rx_data, rx_valid, tx_ready}, 10'd0);
    arst_n = 1'b1;
    wait_q();

    // Write 0x84, 0xA5
    snap();
    bus_start();
    wr_byte(8'h84, ack); check("w_aack", ack, 1'b1);
    wr_byte(8'hA5, ack); check("w_dack", ack, 1'b1);
    check("w_rxv", rxv_cnt - s_rxv, 1);
    check("w_rxdata", rx_data, 8'hA5);
    check("w_stat", status[2:0], 3'b011);
    bus_stop();
    check("w_stop_stat", status[2:0], 3'b000);

    // Foreign address 0x86
    snap();
    bus_start();
    wr_byte(8'h86, ack); check("m_aack", ack, 1'b0);
    check("m_addressed", status[1:0], 2'b01);
    wr_byte(8'h55, ack); check("m_dack", ack, 1'b0);
    check("m_oe", oe_cnt - s_oe, 0);
    bus_stop();
    check("m_busy", status[0], 1'b0);

    // Read 0x85, two bytes of 0x3C, master ACK then NACK
    snap();
    tx_valid = 1'b1; tx_data = 8'h3C;
    bus_start();
    wr_byte(8'h85, ack); check("r_aack", ack, 1'b1);
    check("r_stat", status[2:0], 3'b111);
    rd_bits(b); check("r_byte0", b, 8'h3C);
    bus_bit(1'b0, s);
    rd_bits(b); check("r_byte1", b, 8'h3C);
    bus_bit(1'b1, s);
    check("r_txr", txr_cnt - s_txr, 2);
    check("r_nack", nack_cnt - s_nack, 1);
    bus_stop();
    tx_valid = 1'b0;

    // Underrun read
    snap();
    bus_start();
    wr_byte(8'h85, ack);
    rd_bits(b); check("u_byte", b, 8'hFF);
    bus_bit(1'b1, s);
    check("u_cnt", unr_cnt - s_unr, 1);
    check("u_txr", txr_cnt - s_txr, 0);
    bus_stop();

    // Overflow on data byte 0x11
    snap();
    rx_ready = 1'b0;
    bus_start();
    wr_byte(8'h84, ack); check("o_aack", ack, 1'b1);
    wr_byte(8'h11, ack); check("o_dack", ack, 1'b0);
    check("o_ovf", ovf_cnt - s_ovf, 1);
    check("o_rxv", rxv_cnt - s_rxv, 0);
    bus_stop();
    rx_ready = 1'b1;

    // Repeated START after three data bits, then read 0x85
    snap();
    bus_start();
    wr_byte(8'h84, ack);
    bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s);
    tx_valid = 1'b1; tx_data = 8'h5A;
    bus_start();
    wr_byte(8'h85, ack); check("rs_aack", ack, 1'b1);
    check("rs_stat", status[2:0], 3'b111);
    check("rs_rxv", rxv_cnt - s_rxv, 0);
    rd_bits(b); check("rs_byte", b, 8'h5A);
    bus_bit(1'b1, s);
    bus_stop();
    tx_valid = 1'b0;

    // Asynchronous reset while the address ACK is driven
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(own_addr_bit(i), s);
    sda_m = 1'b1; wait_q();
    check("ar_pre_oe", sda_oe, 1'b1);
    arst_n = 1'b0; #1;
    check("ar_oe", sda_oe, 1'b0);
    check("ar_out", {status, rx_data, rx_valid, tx_ready}, 16'd0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    wait_q();
    snap();
    wr_byte(8'h84, ack); check("ar_nostart", ack, 1'b0);
    check("ar_oe_idle", oe_cnt - s_oe, 0);
    bus_stop();

    // Disable while the address ACK is driven
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(own_addr_bit(i), s);
    sda_m = 1'b1; wait_q();
    check("en_pre_oe", sda_oe, 1'b1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("en_oe", sda_oe, 1'b0);
    check("en_out", {status, rx_data}, 14'd0);
    en = 1'b1;
    scl_i = 1'b1; wait_q(); scl_i = 1'b0; wait_q();
    bus_stop();

    // Randomized transactions against a byte-level model
    for (int t = 0; t < 10; t++) begin
      logic [6:0] own, a7;
      logic       rd, match, alive, v, rdy;
      logic [7:0] d, exp_b, exp_last;
      int         nb, e_rxv, e_ovf, e_txr, e_unr;
      own = 7'($urandom); own_addr = own;
      a7  = ($urandom_range(0, 2) == 0) ? 7'($urandom) : own;
      rd  = 1'($urandom);
      nb  = $urandom_range(1, 3);
      match = (a7 == own);
      e_rxv = 0; e_ovf = 0; e_txr = 0; e_unr = 0;
      snap();
      exp_last = last_rx;
      if (!rd) begin
        bus_start();
        wr_byte({a7, 1'b0}, ack); check("rw_aack", ack, match);
        alive = match;
        for (int k = 0; k < nb; k++) begin
          d = 8'($urandom); rdy = ($urandom_range(0, 3) != 0);
          rx_ready = rdy;
          wr_byte(d, ack);
          check("rw_dack", ack, alive & rdy);
          if (alive) begin
            if (rdy) begin e_rxv++; exp_last = d; end
            else begin e_ovf++; alive = 1'b0; end
          end
        end
        bus_stop();
        check("rw_rxv", rxv_cnt - s_rxv, e_rxv);
        check("rw_ovf", ovf_cnt - s_ovf, e_ovf);
        check("rw_last", last_rx, exp_last);
        rx_ready = 1'b1;
      end else begin
        v = ($urandom_range(0, 3) != 0); d = 8'($urandom);
        tx_valid = v; tx_data = d;
        bus_start();
        wr_byte({a7, 1'b1}, ack); check("rr_aack", ack, match);
        for (int k = 0; k < nb; k++) begin
          rd_bits(b);
          exp_b = (match && v) ? d : 8'hFF;
          check("rr_byte", b, exp_b);
          if (match) begin if (v) e_txr++; else e_unr++; end
          v = ($urandom_range(0, 3) != 0); d = 8'($urandom);
          tx_valid = v; tx_data = d;
          bus_bit((k == nb - 1), s);
        end
        bus_stop();
        check("rr_txr", txr_cnt - s_txr, e_txr);
        check("rr_unr", unr_cnt - s_unr, e_unr);
        check("rr_nack", nack_cnt - s_nack, match ? 1 : 0);
        tx_valid = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  function automatic logic own_addr_bit(input int i);
    logic [7:0] ab;
    ab = {own_addr, 1'b0};
    return ab[i];
  endfunction

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on scl_i/sda_i.
REQ-002 SHALL have parameter ADDR_BITS, default 7, meaning own-address width.
REQ-003 clk  input  1  system clock; one clock domain only.
REQ-004 arst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  block enable; low forces IDLE and releases SDA.
REQ-006 own_addr  input  ADDR_BITS  7-bit slave address to match.
REQ-007 scl_i  input  1  bus SCL level, asynchronous.
REQ-008 sda_i  input  1  bus SDA level, asynchronous.
REQ-009 sda_oe  output  1  1 = pull SDA low (open-drain), 0 = high impedance.
REQ-010 rx_data  output  8  last byte received from master.
REQ-011 rx_valid  output  1  one-cycle pulse, rx_data valid.
REQ-012 rx_ready  input  1  consumer can accept a byte.
REQ-013 tx_data  input  8  byte to return on a master read.
REQ-014 tx_valid  input  1  tx_data available.
REQ-015 tx_ready  output  1  one-cycle pulse, tx_data consumed.
REQ-016 status  output  6  {rx_overflow, tx_underrun, master_nack, rw, addressed, busy}; bits 5:3 are one-cycle pulses.

Function
REQ-017 scl_i/sda_i SHALL pass through SYNC_STAGES flops; all detection uses synced levels; edges detected from synced previous/current values.
REQ-018 START = synced SDA falls while SCL high; STOP = SDA rises while SCL high; both checked before any bit processing in the same cycle.
REQ-019 busy SHALL set on START, clear on STOP; START while busy (repeated start) SHALL restart address phase.
REQ-020 States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
REQ-021 Data SHALL be sampled on SCL rising edge, MSB first, into an 8-bit shift register with 3-bit bit counter; sda_oe changes only on SCL falling edge.
REQ-022 ADDR: after 8th rising edge, addressed set iff bits[7:1]==own_addr; rw=bit0; match -> ADDR_ACK (sda_oe=1 from next falling edge for one SCL period), mismatch -> WAIT_STOP with sda_oe=0.
REQ-023 After ADDR_ACK: rw=0 -> RX_BYTE; rw=1 -> TX_BYTE, loading tx_data at the ACK-release falling edge.
REQ-024 RX_BYTE: on 8th rising edge, if rx_ready=1, rx_data updates, rx_valid pulses 1 cycle, ACK driven; if rx_ready=0, byte dropped, rx_overflow pulses, NACK (sda_oe=0), -> WAIT_STOP.
REQ-025 TX_BYTE: load occurs when tx_valid=1 with tx_ready pulse; if tx_valid=0, 8'hFF SHALL be shifted and tx_underrun pulses; sda_oe = ~shift_reg[7] per bit.
REQ-026 TX_ACK: sda_oe=0; master ACK (SDA=0) at rising edge -> TX_BYTE reload; master NACK -> master_nack pulse, -> WAIT_STOP.
REQ-027 WAIT_STOP: sda_oe=0; leaves only on STOP (-> IDLE) or START (-> ADDR).
REQ-028 STOP or START in any state, including mid-byte, SHALL abort the byte, clear bit counter, release SDA within 1 cycle of detection.
REQ-029 en=0 SHALL behave as synchronous return to IDLE with all outputs at reset values.
REQ-030 Clock stretching SHALL NOT be implemented; SCL is never driven.

Reset
REQ-031 arst_n low SHALL immediately force: state IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_ready=0, status=6'b0, shift register/bit counter 0, synchronizer flops to 1 (idle bus).
REQ-032 Reset assertion mid-transfer SHALL release SDA asynchronously; after release, block waits for a new START.

Structure
REQ-033 i2c_slave_state_t and I2C_ADDR_WIDTH SHALL live in the shared i2c package alongside i2c_cmd_t.
REQ-034 One sub-module i2c_sync SHALL implement synchronizer plus rise/fall edge outputs, instantiated once per line.
REQ-035 Target size 150-300 lines RTL total.

Verification
REQ-036 own_addr=7'h42, master writes 0x84 then 0xA5 with rx_ready=1 -> ACK on both, rx_valid once with rx_data=8'hA5.
REQ-037 Master sends address byte 0x86 (7'h43) -> sda_oe stays 0, addressed=0, state WAIT_STOP until STOP.
REQ-038 Read 0x85, tx_data=8'h3C tx_valid=1, master ACK then NACK -> bits 0011_1100 on SDA twice, tx_ready pulses twice, master_nack once.
REQ-039 Write 0x84 with rx_ready=0 on data byte 0x11 -> NACK, rx_overflow pulse, no rx_valid.
REQ-040 Repeated START after 3 data bits, then 0x85 -> byte discarded, re-addressed, rw=1; separately arst_n low mid-ACK -> sda_oe=0 same cycle, all outputs reset.
